// File: rtl/matrix_addsub_lanes_if.sv
// Operand/result bus and control handshake for the element-wise matrix engine.
// The requester drives the operands and controls; the engine returns status and the result.
interface matrix_addsub_lanes_if #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 32
);
    logic       start;
    logic [1:0] mode;
    logic       abort;
    logic       busy;
    logic       done;
    logic       sat;
    logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] matrix_a;
    logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] matrix_b;
    logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] matrix_c;

    modport master (
        output start, mode, abort, matrix_a, matrix_b,
        input  busy, done, sat, matrix_c
    );

    modport slave (
        input  start, mode, abort, matrix_a, matrix_b,
        output busy, done, sat, matrix_c
    );
endinterface

// File: rtl/matrix_addsub_lanes.sv
// Element-wise saturating matrix add / subtract / accumulate engine.
// Writes LANES row-major elements of matrix_c per cycle.
module matrix_addsub_lanes #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int LANES      = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    matrix_addsub_lanes_if.slave  bus
);
    localparam int N     = ROWS * COLS;
    localparam int BEATS = N / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DW    = DATA_WIDTH;

    localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

    generate
        if (LANES < 1 || (N % LANES) != 0) begin : g_lanes_chk
            $error("ROWS*COLS must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [1:0]        mode_q, mode_d;
    logic              sat_q, sat_d;
    logic [N*DW-1:0]   c_q, c_d;
    logic [N*DW-1:0]   a_flat, b_flat;

    logic [LANES-1:0][DW-1:0] lane_res;
    logic [LANES-1:0]         lane_ovf;

    logic [DW-1:0]     a_e, b_e, c_e;
    logic signed [DW:0] sum;
    int                ri;
    int                wi;

    assign a_flat = bus.matrix_a;
    assign b_flat = bus.matrix_b;

    // One adder per lane; widened by a bit so the clamp sees the true result.
    always_comb begin
        lane_res = '0;
        lane_ovf = '0;
        a_e      = '0;
        b_e      = '0;
        c_e      = '0;
        sum      = '0;
        ri       = 0;
        for (int l = 0; l < LANES; l++) begin
            ri  = int'(beat_q) * LANES + l;
            a_e = a_flat[ri*DW +: DW];
            b_e = b_flat[ri*DW +: DW];
            c_e = c_q[ri*DW +: DW];
            unique case (1'b1)
                (mode_q == 2'd2): sum = $signed({c_e[DW-1], c_e})
                                      + $signed({a_e[DW-1], a_e});
                (mode_q == 2'd1): sum = $signed({a_e[DW-1], a_e})
                                      - $signed({b_e[DW-1], b_e});
                default:          sum = $signed({a_e[DW-1], a_e})
                                      + $signed({b_e[DW-1], b_e});
            endcase
            lane_ovf[l] = sum[DW] ^ sum[DW-1];
            if (lane_ovf[l]) begin
                lane_res[l] = sum[DW] ? MINV : MAXV;
            end else begin
                lane_res[l] = sum[DW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        mode_d  = mode_q;
        sat_d   = sat_q;
        c_d     = c_q;
        wi      = 0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_COMPUTE;
                    mode_d  = bus.mode;
                    sat_d   = 1'b0;
                    beat_d  = '0;
                end
            end
            S_COMPUTE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    beat_d  = '0;
                end else begin
                    for (int l = 0; l < LANES; l++) begin
                        wi = int'(beat_q) * LANES + l;
                        c_d[wi*DW +: DW] = lane_res[l];
                    end
                    sat_d = sat_q | (|lane_ovf);
                    if (beat_q == BW'(BEATS - 1)) begin
                        state_d = S_DONE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            mode_q  <= '0;
            sat_q   <= 1'b0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            mode_q  <= mode_d;
            sat_q   <= sat_d;
            c_q     <= c_d;
        end
    end

    assign bus.busy     = (state_q == S_COMPUTE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.sat      = sat_q;
    assign bus.matrix_c = c_q;
endmodule

// File: tb/tb_matrix_addsub_lanes.sv
// Bench for matrix_addsub_lanes: a LANES=1 and a LANES=4 instance (4x4, 16-bit)
// checked each cycle against an element-level model plus literal expectations.
module tb_matrix_addsub_lanes;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int DW = 16;
    localparam int N  = R * C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            start_s [2];
    logic            abort_s [2];
    logic [1:0]      mode_s  [2];
    logic [N*DW-1:0] a_s     [2];
    logic [N*DW-1:0] b_s     [2];
    logic            busy_o  [2];
    logic            done_o  [2];
    logic            sat_o   [2];
    logic [N*DW-1:0] c_o     [2];

    matrix_addsub_lanes_if #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW)) if0 ();
    matrix_addsub_lanes_if #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW)) if1 ();

    assign if0.start    = start_s[0];
    assign if0.abort    = abort_s[0];
    assign if0.mode     = mode_s[0];
    assign if0.matrix_a = a_s[0];
    assign if0.matrix_b = b_s[0];
    assign busy_o[0]    = if0.busy;
    assign done_o[0]    = if0.done;
    assign sat_o[0]     = if0.sat;
    assign c_o[0]       = if0.matrix_c;

    assign if1.start    = start_s[1];
    assign if1.abort    = abort_s[1];
    assign if1.mode     = mode_s[1];
    assign if1.matrix_a = a_s[1];
    assign if1.matrix_b = b_s[1];
    assign busy_o[1]    = if1.busy;
    assign done_o[1]    = if1.done;
    assign sat_o[1]     = if1.sat;
    assign c_o[1]       = if1.matrix_c;

    matrix_addsub_lanes #(.ROWS(R), .COLS(C), .LANES(1), .DATA_WIDTH(DW)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    matrix_addsub_lanes #(.ROWS(R), .COLS(C), .LANES(4), .DATA_WIDTH(DW)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    int vecs = 0;
    int miss = 0;
    bit chk_en = 1'b0;

    function automatic logic signed [31:0] el(input logic [N*DW-1:0] v, input int k);
        logic signed [DW-1:0] e;
        e = v[k*DW +: DW];
        return 32'(e);
    endfunction

    task automatic chk(input string nm, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: element values and status as the rules define them.
    int mc      [2][N];
    bit m_act   [2];
    bit m_donep [2];
    bit m_sat   [2];
    int m_t     [2];
    int m_mode  [2];

    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            int L;
            int k;
            int x;
            L = (j == 0) ? 1 : 4;
            if (rst) begin
                m_act[j]   <= 1'b0;
                m_donep[j] <= 1'b0;
                m_sat[j]   <= 1'b0;
                m_t[j]     <= 0;
                for (int e = 0; e < N; e++) mc[j][e] <= 0;
            end else if (m_donep[j]) begin
                m_donep[j] <= 1'b0;
            end else if (m_act[j]) begin
                if (abort_s[j]) begin
                    m_act[j] <= 1'b0;
                end else begin
                    for (int l = 0; l < L; l++) begin
                        k = m_t[j] * L + l;
                        case (m_mode[j])
                            2:       x = mc[j][k] + el(a_s[j], k);
                            1:       x = el(a_s[j], k) - el(b_s[j], k);
                            default: x = el(a_s[j], k) + el(b_s[j], k);
                        endcase
                        if (x > 32767) begin
                            x = 32767;
                            m_sat[j] <= 1'b1;
                        end else if (x < -32768) begin
                            x = -32768;
                            m_sat[j] <= 1'b1;
                        end
                        mc[j][k] <= x;
                    end
                    m_t[j] <= m_t[j] + 1;
                    if (m_t[j] + 1 == N / L) begin
                        m_act[j]   <= 1'b0;
                        m_donep[j] <= 1'b1;
                    end
                end
            end else if (start_s[j]) begin
                m_act[j]  <= 1'b1;
                m_t[j]    <= 0;
                m_mode[j] <= int'(mode_s[j]);
                m_sat[j]  <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("busy%0d", j), 32'(busy_o[j]), 32'(m_act[j]));
                chk($sformatf("done%0d", j), 32'(done_o[j]), 32'(m_donep[j]));
                chk($sformatf("sat%0d", j), 32'(sat_o[j]), 32'(m_sat[j]));
                for (int k = 0; k < N; k++)
                    chk($sformatf("c%0d[%0d]", j, k), el(c_o[j], k), mc[j][k]);
            end
        end
    end

    task automatic fill(input int j, input int sel);
        for (int k = 0; k < N; k++) begin
            case (sel)
                0: begin a_s[j][k*DW +: DW] = 16'(k);       b_s[j][k*DW +: DW] = 16'd100;  end
                1: begin a_s[j][k*DW +: DW] = 16'h7FF0;     b_s[j][k*DW +: DW] = 16'hFFE0; end
                2: begin a_s[j][k*DW +: DW] = 16'h1234;     b_s[j][k*DW +: DW] = 16'h1234; end
                3: begin a_s[j][k*DW +: DW] = (k % 2 == 0) ? 16'hFFFF : 16'h0000;
                         b_s[j][k*DW +: DW] = 16'h8000; end
                4: begin a_s[j][k*DW +: DW] = 16'd3;        b_s[j][k*DW +: DW] = 16'h5555; end
                5: begin a_s[j][k*DW +: DW] = 16'h8000;     b_s[j][k*DW +: DW] = 16'h0000; end
                6: begin a_s[j][k*DW +: DW] = 16'(k);       b_s[j][k*DW +: DW] = 16'(10*k + 7); end
                default: begin a_s[j][k*DW +: DW] = 16'(k + 1); b_s[j][k*DW +: DW] = 16'd1000; end
            endcase
        end
    endtask

    task automatic run(input int j, input logic [1:0] md, output int lat);
        int n;
        @(negedge clk);
        start_s[j] = 1'b1;
        mode_s[j]  = md;
        @(negedge clk);
        start_s[j] = 1'b0;
        n = 0;
        while (done_o[j] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        lat = n + 1;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int n;
        int dn;
        for (int j = 0; j < 2; j++) begin
            start_s[j] = 1'b0;
            abort_s[j] = 1'b0;
            mode_s[j]  = 2'd0;
            a_s[j]     = '0;
            b_s[j]     = '0;
        end
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy_o[0]), 0);
        chk("rst_c", el(c_o[0], 5), 0);
        rst = 1'b0;

        // Plain add, both ADD encodings
        fill(0, 0);
        run(0, 2'd0, lat);
        chk("t1_lat", lat, 17);
        chk("t1_c23", el(c_o[0], 11), 111);
        chk("t1_sat", 32'(sat_o[0]), 0);
        run(0, 2'd3, lat);
        chk("t1b_lat", lat, 17);
        chk("t1b_c00", el(c_o[0], 0), 100);

        // Saturating subtract, then clear
        fill(0, 1);
        run(0, 2'd1, lat);
        chk("t2_c", el(c_o[0], 7), 32767);
        chk("t2_sat", 32'(sat_o[0]), 1);
        fill(0, 2);
        run(0, 2'd1, lat);
        chk("t2b_c", el(c_o[0], 7), 0);
        chk("t2b_sat", 32'(sat_o[0]), 0);

        // Subtracting MIN: exact for -1, clamps for 0
        fill(0, 3);
        run(0, 2'd1, lat);
        chk("t2c_c0", el(c_o[0], 0), 32767);
        chk("t2c_c1", el(c_o[0], 1), 32767);
        chk("t2c_sat", 32'(sat_o[0]), 1);

        // Accumulate from reset, ignore abort while idle
        @(negedge clk);
        rst = 1'b1;
        abort_s[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        abort_s[0] = 1'b0;
        fill(0, 4);
        run(0, 2'd2, lat);
        chk("t3_acc1", el(c_o[0], 9), 3);
        run(0, 2'd2, lat);
        chk("t3_acc2", el(c_o[0], 9), 6);
        fill(0, 5);
        run(0, 2'd2, lat);
        chk("t3_acc3", el(c_o[0], 9), -32762);
        chk("t3_sat3", 32'(sat_o[0]), 0);
        run(0, 2'd2, lat);
        chk("t3_acc4", el(c_o[0], 9), -32768);
        chk("t3_sat4", 32'(sat_o[0]), 1);
        run(0, 2'd2, lat);
        chk("t3_acc5", el(c_o[0], 15), -32768);

        // Four lanes; start held through busy and done
        fill(1, 6);
        @(negedge clk);
        start_s[1] = 1'b1;
        mode_s[1]  = 2'd0;
        @(negedge clk);
        chk("t4_pre", el(c_o[1], 0), 0);
        @(negedge clk);
        chk("t4_row0", el(c_o[1], 3), 40);
        chk("t4_row1", el(c_o[1], 4), 0);
        n = 1;
        while (done_o[1] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_lat", n + 1, 5);
        @(negedge clk);
        start_s[1] = 1'b0;
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dn += int'(done_o[1]);
        end
        chk("t4_nodup", dn, 0);
        chk("t4_c15", el(c_o[1], 15), 15 + 157);

        // Abort in the third compute cycle
        fill(0, 7);
        @(negedge clk);
        start_s[0] = 1'b1;
        mode_s[0]  = 2'd0;
        @(negedge clk);
        start_s[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        chk("t5_busy", 32'(busy_o[0]), 0);
        chk("t5_c0", el(c_o[0], 0), 1001);
        chk("t5_c1", el(c_o[0], 1), 1002);
        chk("t5_c2", el(c_o[0], 2), -32768);
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            dn += int'(done_o[0]);
        end
        chk("t5_nodone", dn, 0);

        // Reset mid-operation, then a normal run
        fill(0, 1);
        @(negedge clk);
        start_s[0] = 1'b1;
        mode_s[0]  = 2'd1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", 32'(busy_o[0]), 0);
        chk("t6_sat", 32'(sat_o[0]), 0);
        chk("t6_c0", el(c_o[0], 0), 0);
        fill(0, 0);
        run(0, 2'd0, lat);
        chk("t6_lat", lat, 17);
        chk("t6_c15", el(c_o[0], 15), 115);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "timeout");
    end
endmodule
